// File: rtl/load_store_unit.sv
// Load/store unit: a single outstanding memory op on a simple req/ack bus.
// Lanes are little-endian, store data is replicated across lanes and loads are extended.
module load_store_unit #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        mem_wr,
    input  logic [1:0]  mem_size,
    input  logic        load_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        timeout,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t      state, state_nx;
    logic        l_wr, l_uns;
    logic [1:0]  l_size;
    logic [31:0] l_addr, l_wdata;
    logic [7:0]  cnt;
    logic        mis_r, to_r;
    logic [31:0] rd_r;
    logic        bad_align;
    logic [7:0]  bsel;
    logic [15:0] hsel;
    logic [31:0] ld_ext;
    logic        in_req;

    always_comb begin
        bad_align = (mem_size == 2'b11)
                  | ((mem_size == 2'b01) & addr[0])
                  | ((mem_size == 2'b10) & (addr[1:0] != 2'b00));
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = bad_align ? RESP : REQ;
            REQ:     if (bus_ack || cnt == CNT_LAST) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Lane select and extension of the returned word, from the latched op.
    always_comb begin
        case (l_addr[1:0])
            2'd0:    bsel = bus_rdata[7:0];
            2'd1:    bsel = bus_rdata[15:8];
            2'd2:    bsel = bus_rdata[23:16];
            default: bsel = bus_rdata[31:24];
        endcase
        hsel = l_addr[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (l_size)
            2'b00:   ld_ext = {{24{~l_uns & bsel[7]}}, bsel};
            2'b01:   ld_ext = {{16{~l_uns & hsel[15]}}, hsel};
            default: ld_ext = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            l_wr    <= 1'b0;
            l_uns   <= 1'b0;
            l_size  <= 2'b00;
            l_addr  <= '0;
            l_wdata <= '0;
            cnt     <= '0;
            mis_r   <= 1'b0;
            to_r    <= 1'b0;
            rd_r    <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (start) begin
                    l_wr    <= mem_wr;
                    l_uns   <= load_unsigned;
                    l_size  <= mem_size;
                    l_addr  <= addr;
                    l_wdata <= wdata;
                    cnt     <= '0;
                    mis_r   <= bad_align;
                    to_r    <= 1'b0;
                    rd_r    <= '0;
                end
                REQ: begin
                    // ack takes priority over an expiring counter
                    if (bus_ack)               rd_r <= l_wr ? 32'h0 : ld_ext;
                    else if (cnt == CNT_LAST)  to_r <= 1'b1;
                    else                       cnt  <= cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign in_req = (state == REQ);

    always_comb begin
        bus_req   = in_req;
        bus_we    = in_req & l_wr;
        bus_addr  = in_req ? {l_addr[31:2], 2'b00} : 32'h0;
        bus_be    = 4'b0000;
        bus_wdata = 32'h0;
        if (in_req) begin
            case (l_size)
                2'b00: begin
                    bus_be    = 4'b0001 << l_addr[1:0];
                    bus_wdata = {4{l_wdata[7:0]}};
                end
                2'b01: begin
                    bus_be    = l_addr[1] ? 4'b1100 : 4'b0011;
                    bus_wdata = {2{l_wdata[15:0]}};
                end
                default: begin
                    bus_be    = 4'b1111;
                    bus_wdata = l_wdata;
                end
            endcase
        end
    end

    assign busy     = (state != IDLE);
    assign done     = (state == RESP);
    assign misalign = done & mis_r;
    assign timeout  = done & to_r;
    assign rdata    = done ? rd_r : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table of single ops plus
// hand-written restart-while-busy and reset-during-request sequences.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start, mem_wr, load_unsigned, bus_ack;
    logic [1:0]  mem_size;
    logic [31:0] addr, wdata, bus_rdata;
    logic        busy, done, misalign, timeout, bus_req, bus_we;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;

    int total = 0;
    int bad   = 0;
    int txn   = 0;
    int dones = 0;

    load_store_unit #(.TIMEOUT_CYC(4)) dut (
        .clk(clk), .rstn(rstn), .start(start), .mem_wr(mem_wr),
        .mem_size(mem_size), .load_unsigned(load_unsigned), .addr(addr),
        .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
        .misalign(misalign), .timeout(timeout), .bus_req(bus_req),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus_req && bus_ack) txn++;
        if (done) dones++;
    end

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] brd;
        int          waits;   // wait cycles before ack; >=4 means never ack
        logic [3:0]  be;
        logic [31:0] bwd;
        logic [31:0] rd;
        logic        mis;
        logic        to;
    } vec_t;

    vec_t v[13];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", n, act, exp, $time);
        end
    endtask

    task automatic do_op(input vec_t t, input bit repulse);
        int n;
        @(negedge clk);
        mem_wr = t.wr; mem_size = t.size; load_unsigned = t.uns;
        addr = t.addr; wdata = t.wdata; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (t.mis) begin
            chk("mis_done", 32'(done), 1);
            chk("mis_flag", 32'(misalign), 1);
            chk("mis_to", 32'(timeout), 0);
            chk("mis_rdata", rdata, 0);
            chk("mis_busreq", 32'(bus_req), 0);
        end else begin
            n = (t.waits >= 4) ? 4 : t.waits + 1;
            for (int i = 0; i < n; i++) begin
                chk("req", 32'(bus_req), 1);
                chk("we", 32'(bus_we), 32'(t.wr));
                chk("baddr", bus_addr, {t.addr[31:2], 2'b00});
                chk("be", 32'(bus_be), 32'(t.be));
                chk("bwdata", bus_wdata, t.bwd);
                chk("early_done", 32'(done), 0);
                if (i == t.waits) begin
                    bus_ack = 1'b1; bus_rdata = t.brd;
                end else begin
                    bus_rdata = 32'h5A5A5A5A;
                end
                if (repulse) start = 1'b1;
                @(negedge clk);
                bus_ack = 1'b0; start = 1'b0;
            end
            chk("done", 32'(done), 1);
            chk("misalign", 32'(misalign), 0);
            chk("timeout", 32'(timeout), 32'(t.to));
            chk("rdata", rdata, t.rd);
            chk("req_off", 32'(bus_req), 0);
            chk("we_off", 32'(bus_we), 0);
        end
        @(negedge clk);
        chk("busy_after", 32'(busy), 0);
        chk("done_after", 32'(done), 0);
        chk("rdata_after", rdata, 0);
    endtask

    initial begin
        int t0;
        //          wr    size   uns   addr          wdata         brd           w  be       bwd           rd            mis   to
        v[0]  = '{1'b0, 2'b00, 1'b0, 32'h00001003, 32'h00000000, 32'h80FFFFFF, 0, 4'b1000, 32'h00000000, 32'hFFFFFF80, 1'b0, 1'b0};
        v[1]  = '{1'b1, 2'b01, 1'b0, 32'h00002002, 32'h1234ABCD, 32'h00000000, 3, 4'b1100, 32'hABCDABCD, 32'h00000000, 1'b0, 1'b0};
        v[2]  = '{1'b0, 2'b10, 1'b0, 32'h00003001, 32'h00000000, 32'h00000000, 0, 4'b0000, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
        v[3]  = '{1'b0, 2'b11, 1'b0, 32'h00004000, 32'h00000000, 32'h00000000, 0, 4'b0000, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
        v[4]  = '{1'b0, 2'b10, 1'b0, 32'h00000100, 32'h00000000, 32'hDEADBEEF, 9, 4'b1111, 32'h00000000, 32'h00000000, 1'b0, 1'b1};
        v[5]  = '{1'b0, 2'b10, 1'b0, 32'h00000100, 32'h00000000, 32'hDEADBEEF, 3, 4'b1111, 32'h00000000, 32'hDEADBEEF, 1'b0, 1'b0};
        v[6]  = '{1'b0, 2'b01, 1'b1, 32'h00000010, 32'h00000000, 32'h0000F00F, 0, 4'b0011, 32'h00000000, 32'h0000F00F, 1'b0, 1'b0};
        v[7]  = '{1'b0, 2'b01, 1'b0, 32'h00000012, 32'h00000000, 32'h80011234, 1, 4'b1100, 32'h00000000, 32'hFFFF8001, 1'b0, 1'b0};
        v[8]  = '{1'b0, 2'b00, 1'b1, 32'h00000005, 32'h00000000, 32'h11223344, 0, 4'b0010, 32'h00000000, 32'h00000033, 1'b0, 1'b0};
        v[9]  = '{1'b1, 2'b00, 1'b0, 32'h00000006, 32'h000000A5, 32'hFFFFFFFF, 1, 4'b0100, 32'hA5A5A5A5, 32'h00000000, 1'b0, 1'b0};
        v[10] = '{1'b1, 2'b10, 1'b0, 32'h00000008, 32'hCAFEF00D, 32'hFFFFFFFF, 0, 4'b1111, 32'hCAFEF00D, 32'h00000000, 1'b0, 1'b0};
        v[11] = '{1'b0, 2'b01, 1'b0, 32'h00000011, 32'h00000000, 32'h00000000, 0, 4'b0000, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
        v[12] = '{1'b1, 2'b10, 1'b0, 32'h00000000, 32'h76543210, 32'h00000000, 0, 4'b1111, 32'h76543210, 32'h00000000, 1'b0, 1'b0};

        rstn = 1'b0; start = 1'b0; mem_wr = 1'b0; mem_size = 2'b00; load_unsigned = 1'b0;
        addr = '0; wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_req", 32'(bus_req), 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_be", 32'(bus_be), 0);
        chk("rst_wdata", bus_wdata, 0);
        chk("rst_rdata", rdata, 0);
        rstn = 1'b1;

        for (int i = 0; i < 12; i++) do_op(v[i], 1'b0);

        // start re-pulsed every busy cycle must yield exactly one bus transaction
        t0 = txn;
        do_op(v[6], 1'b1);
        repeat (2) @(negedge clk);
        chk("repulse_txn", 32'(txn - t0), 1);
        chk("repulse_idle", 32'(busy), 0);

        // reset during REQ: bus_req drops at once, no done pulse
        @(negedge clk);
        mem_wr = 1'b0; mem_size = 2'b10; addr = 32'h20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("pre_rst_req", 32'(bus_req), 1);
        t0 = dones;
        #2 rstn = 1'b0;
        #1;
        chk("rst_mid_req", 32'(bus_req), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_be", 32'(bus_be), 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_no_done", 32'(dones - t0), 0);
        do_op(v[12], 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16: maximum REQ cycles without bus_ack before abort (legal range 2..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle request to begin a memory op; sampled only in IDLE.
REQ-005 mem_wr  input  1  1 = store, 0 = load.
REQ-006 mem_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-007 load_unsigned  input  1  1 = zero-extend load, 0 = sign-extend.
REQ-008 addr  input  32  effective address, produced by the ALU result output.
REQ-009 wdata  input  32  store data, low bits significant for byte/half.
REQ-010 busy  output  1  high whenever state is not IDLE; CPU stall.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 rdata  output  32  extended load data, valid while done=1.
REQ-013 misalign  output  1  valid with done; op rejected for alignment or reserved size.
REQ-014 timeout  output  1  valid with done; bus never acknowledged.
REQ-015 bus_req, bus_we  output  1 each  bus request and write strobe.
REQ-016 bus_addr  output  32  word address, {addr[31:2],2'b00}.
REQ-017 bus_be  output  4  byte enables, bit i = byte lane i (little-endian).
REQ-018 bus_wdata  output  32  lane-replicated store data.
REQ-019 bus_ack  input  1  bus completes the held request this cycle.
REQ-020 bus_rdata  input  32  read word, valid when bus_ack=1.

Function
REQ-021 FSM states IDLE, REQ, RESP; reset state IDLE.
REQ-022 IDLE + start: latch mem_wr, mem_size, load_unsigned, addr, wdata; misaligned (half with addr[0]=1, word with addr[1:0]!=0) or mem_size=11 -> RESP with misalign flag, no bus access; else -> REQ, timeout counter cleared.
REQ-023 IDLE without start: stay; start while busy is ignored, no queuing.
REQ-024 REQ: bus_req=1; bus_addr, bus_we, bus_be, bus_wdata driven from latched values and held stable until bus_ack.
REQ-025 REQ + bus_ack: capture bus_rdata (loads) -> RESP; bus_req drops next cycle.
REQ-026 REQ without bus_ack: counter increments; counter reaching TIMEOUT_CYC-1 without ack -> RESP with timeout flag.
REQ-027 bus_ack in the same cycle the counter expires: ack wins, timeout=0.
REQ-028 RESP: done=1 exactly one cycle with misalign/timeout/rdata valid -> IDLE; busy=0 in the following cycle.
REQ-029 Latency: aligned op with ack on first REQ cycle -> start at cycle N, bus_req at N+1, done at N+2; each wait cycle adds one.
REQ-030 Byte: bus_be = 1 << addr[1:0]; bus_wdata = wdata[7:0] replicated x4.
REQ-031 Half: bus_be = 0011 (addr[1]=0) or 1100 (addr[1]=1); bus_wdata = wdata[15:0] replicated x2.
REQ-032 Word: bus_be = 1111; bus_wdata = wdata.
REQ-033 Load rdata: selected lane shifted to bit 0, extended to 32 bits per load_unsigned; word loads unmodified.
REQ-034 rdata = 0 on stores, misaligned ops and timeouts; bus_we = 0 whenever bus_req = 0.
REQ-035 Outputs other than in RESP: done, misalign, timeout, rdata all 0.

Reset
REQ-036 rstn low asynchronously forces IDLE; busy, done, rdata, misalign, timeout, bus_req, bus_we, bus_addr, bus_be, bus_wdata, counter all 0.
REQ-037 Reset mid-REQ drops bus_req immediately; no done pulse issued for the aborted op.
REQ-038 After rstn rises, start is honoured on the first rising edge.

Verification
REQ-039 Load byte signed, addr=0x1003, bus_rdata=0x80FFFFFF, ack first cycle -> bus_be=1000, bus_addr=0x1000, done at N+2, rdata=0xFFFFFF80.
REQ-040 Store half, addr=0x2002, wdata=0x1234ABCD, ack after 3 wait cycles -> bus_we=1, bus_be=1100, bus_wdata=0xABCDABCD held 4 cycles, done at N+5, rdata=0.
REQ-041 Load word addr=0x3001 -> no bus_req, done at N+1 with misalign=1; mem_size=11 at aligned addr -> same response.
REQ-042 TIMEOUT_CYC=4, no ack -> bus_req high 4 cycles, done with timeout=1, rdata=0; repeat with ack on the 4th cycle -> timeout=0.
REQ-043 Load half unsigned addr=0x10, bus_rdata=0x0000F00F -> rdata=0x0000F00F; same op with start re-pulsed while busy -> exactly one bus transaction.
REQ-044 rstn asserted during REQ -> bus_req=0 same cycle, no done; post-reset store word addr=0x0 completes normally.
